// File: rtl/ex_div_unit.sv
// Iterative restoring divider for the EX stage: one quotient bit per clock, result {hi=rem, lo=quo}.
// Optional macro DIV_ZERO_FLAG_EN adds a dbz_o output flagging divide-by-zero results.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               dbz_o
`endif
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DIVZERO = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               neg1, neg2, accept;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; -MIN wraps to MIN, which is the correct unsigned magnitude.
  always_comb begin
    neg1   = signed_i & opdata1_i[WIDTH-1];
    neg2   = signed_i & opdata2_i[WIDTH-1];
    mag1   = neg1 ? -opdata1_i : opdata1_i;
    mag2   = neg2 ? -opdata2_i : opdata2_i;
    accept = (state_q == S_FREE) & start_i & ~annul_i;
  end

  // Trial subtract of the divisor from the shifted partial remainder; MSB set means "does not fit".
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (accept) begin
          if (opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = mag1;
            dvs_d   = mag2;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
          end
        end
      end
      S_BUSY: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = S_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_DIVZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // END deliberately releases the stall so EX advances in the ready cycle.
  always_comb begin
    stallreq_o = accept | (state_q == S_BUSY) | (state_q == S_DIVZERO);
    result_o   = result_q;
    ready_o    = ready_q;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dbz_q, dbz_d;

  always_comb begin
    dbz_d = dbz_q;
    if (state_q == S_DIVZERO)                          dbz_d = 1'b1;
    else if (state_q != S_END || annul_i || !start_i) dbz_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) dbz_q <= 1'b0;
    else     dbz_q <= dbz_d;
  end

  assign dbz_o = dbz_q;
`endif

endmodule
